// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and FETCH/HALT control.
// Define INST_FETCH_PERF_EN to add the fetch_count/bubble_count performance counters.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_INST = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misaligned,
`ifdef INST_FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count,
`endif
    output logic        halted
);

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(NUM_INST * 4);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (RESET_PC >= PC_LIMIT) ? ST_HALT : ST_FETCH;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] redirect_tgt_c;
    logic [XLEN-1:0] pc_inc_c;

    assign redirect_tgt_c = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc_c       = pc_q + PC_STEP;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Next-state: redirect beats stall, stall beats advance
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misaligned_d  = 1'b0;
        if (redirect) begin
            pc_d          = redirect_tgt_c;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
            misaligned_d  = |redirect_pc[1:0];
            state_d       = (redirect_tgt_c >= PC_LIMIT) ? ST_HALT : ST_FETCH;
        end else if (!stall) begin
            unique case (state_q)
                ST_FETCH: begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = instruction;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_inc_c;
                    if (pc_inc_c >= PC_LIMIT) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [XLEN-1:0] fetch_count_q, bubble_count_q;
    logic            fetch_inc_c, bubble_inc_c;

    assign fetch_inc_c  = !redirect && !stall && (state_q == ST_FETCH);
    assign bubble_inc_c = !stall && (redirect || (state_q == ST_HALT));

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (fetch_inc_c && (fetch_count_q != '1)) begin
                fetch_count_q <= fetch_count_q + XLEN'(1);
            end
            if (bubble_inc_c && (bubble_count_q != '1)) begin
                bubble_count_q <= bubble_count_q + XLEN'(1);
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

    assign pc          = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign misaligned  = misaligned_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a 128-word instance and a 4-word instance driven from vector tables.
module tb_inst_fetch;

    logic        clk;
    logic [31:0] mem [128];

    logic        b_reset, b_stall, b_redirect;
    logic [31:0] b_redirect_pc, b_pc, b_instr, b_if_id_pc, b_if_id_instr;
    logic        b_if_id_valid, b_misaligned, b_halted;

    logic        s_reset, s_stall, s_redirect;
    logic [31:0] s_redirect_pc, s_pc, s_instr, s_if_id_pc, s_if_id_instr;
    logic        s_if_id_valid, s_misaligned, s_halted;

    inst_fetch #(.RESET_PC(32'h0), .NUM_INST(128)) u_big (
        .clk(clk), .reset(b_reset), .pc(b_pc), .instruction(b_instr),
        .stall(b_stall), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
        .if_id_pc(b_if_id_pc), .if_id_instr(b_if_id_instr), .if_id_valid(b_if_id_valid),
        .misaligned(b_misaligned), .halted(b_halted)
    );

    inst_fetch #(.RESET_PC(32'h0), .NUM_INST(4)) u_small (
        .clk(clk), .reset(s_reset), .pc(s_pc), .instruction(s_instr),
        .stall(s_stall), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
        .if_id_pc(s_if_id_pc), .if_id_instr(s_if_id_instr), .if_id_valid(s_if_id_valid),
        .misaligned(s_misaligned), .halted(s_halted)
    );

    // Combinational instruction memories, zero outside each window
    always_comb begin
        b_instr = (b_pc < 32'd512) ? mem[b_pc[8:2]] : 32'h0;
        s_instr = (s_pc < 32'd16)  ? mem[s_pc[8:2]] : 32'h0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp;
    int   n_err;
    int   row;

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input bit sel, input logic rst, input logic stl, input logic rdr,
                                input logic [31:0] rpc, input logic [31:0] e_pc,
                                input logic [31:0] e_ifpc, input logic [31:0] e_instr,
                                input logic e_valid, input logic e_mis, input logic e_halt);
        vec_t v;
        v.sel = sel; v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_mis = e_mis; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one vector on the selected instance; the other one is parked in stall
    task automatic drive(input vec_t v);
        b_reset = 1'b0; b_stall = 1'b1; b_redirect = 1'b0; b_redirect_pc = 32'h0;
        s_reset = 1'b0; s_stall = 1'b1; s_redirect = 1'b0; s_redirect_pc = 32'h0;
        if (v.sel) begin
            s_reset = v.rst; s_stall = v.stl; s_redirect = v.rdr; s_redirect_pc = v.rpc;
        end else begin
            b_reset = v.rst; b_stall = v.stl; b_redirect = v.rdr; b_redirect_pc = v.rpc;
        end
        sb_q.push_back(v);
    endtask

    task automatic step_and_check();
        vec_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard row %0d: got empty queue expected one entry", row);
        end else begin
            e = sb_q.pop_front();
            if (e.sel) begin
                chk("pc",          s_pc,                 e.e_pc);
                chk("if_id_pc",    s_if_id_pc,           e.e_ifpc);
                chk("if_id_instr", s_if_id_instr,        e.e_instr);
                chk("if_id_valid", 32'(s_if_id_valid),   32'(e.e_valid));
                chk("misaligned",  32'(s_misaligned),    32'(e.e_mis));
                chk("halted",      32'(s_halted),        32'(e.e_halt));
            end else begin
                chk("pc",          b_pc,                 e.e_pc);
                chk("if_id_pc",    b_if_id_pc,           e.e_ifpc);
                chk("if_id_instr", b_if_id_instr,        e.e_instr);
                chk("if_id_valid", 32'(b_if_id_valid),   32'(e.e_valid));
                chk("misaligned",  32'(b_misaligned),    32'(e.e_mis));
                chk("halted",      32'(b_halted),        32'(e.e_halt));
            end
        end
        row++;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        row   = 0;
        for (int i = 0; i < 128; i++) mem[i] = w(i);
        b_reset = 1'b1; b_stall = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0;
        s_reset = 1'b1; s_stall = 1'b0; s_redirect = 1'b0; s_redirect_pc = 32'h0;

        //            sel rst stl rdr rpc           pc            ifpc          instr    v  mis halt
        // 128-word instance: sequential fetch, stall, redirect, misalign, reset, halt
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,     32'h0,     32'h0,     32'h0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h4,     32'h0,     w(0),    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h8,     32'h4,     w(1),    1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,     32'h8,     32'h4,     w(1),    1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,     32'h8,     32'h4,     w(1),    1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'hC,     32'h8,     w(2),    1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h28,    32'h28,    32'h8,     32'h0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h2C,    32'h28,    w(10),   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h2A,    32'h28,    32'h28,    32'h0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h2C,    32'h28,    w(10),   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h30,    32'h2C,    w(11),   1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h40,    32'h0,     32'h0,     32'h0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h200,   32'h200,   32'h0,     32'h0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h200,   32'h0,     32'h0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1FC,   32'h1FC,   32'h0,     32'h0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h200,   32'h1FC,   w(127),  1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,     32'h200,   32'h1FC,   32'h0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,     32'h200,   32'h1FC,   32'h0,   0, 0, 1));
        // 4-word instance: run off the end, halt, resume on redirect to 0
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,     32'h0,     32'h0,     32'h0,   0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'h4,     32'h0,     w(0),    1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'h8,     32'h4,     w(1),    1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'hC,     32'h8,     w(2),    1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'h10,    32'hC,     w(3),    1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'h10,    32'hC,     32'h0,   0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0,     32'h0,     32'hC,     32'h0,   0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,     32'h4,     32'h0,     w(0),    1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step_and_check();
        end

        // Misaligned out-of-window redirect: halt with a one-cycle misaligned pulse, then hold
        drive(mk(1, 0, 0, 1, 32'h12, 32'h10, 32'h0, 32'h0, 0, 1, 1));
        step_and_check();
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 0, 0, 0, 32'h0, 32'h10, 32'h0, 32'h0, 0, 0, 1));
            step_and_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NUM_INST, default 128: instruction memory depth in words; fetch window is [0, NUM_INST*4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  output  32  byte address driven to instruction memory; memory returns a word combinationally.
REQ-006 instruction  input  32  word at memory[pc>>2], valid in the same cycle as pc.
REQ-007 stall  input  1  back-pressure from decode; hold pc and the IF/ID register.
REQ-008 redirect  input  1  taken branch or jump from execute; single-cycle pulse.
REQ-009 redirect_pc  input  32  branch or jump target; sampled only when redirect=1.
REQ-010 if_id_pc  output  32  registered address of the fetched instruction.
REQ-011 if_id_instr  output  32  registered fetched instruction; 32'b0 (nop) when not valid.
REQ-012 if_id_valid  output  1  if_id_instr holds a real fetched instruction.
REQ-013 misaligned  output  1  one-cycle pulse: accepted redirect_pc had bits [1:0] != 0.
REQ-014 halted  output  1  pc is outside the fetch window and fetch has stopped.

Function
REQ-015 Event priority is reset > redirect > stall > normal advance.
REQ-016 Normal advance (not halted, no stall, no redirect): if_id_pc<=pc, if_id_instr<=instruction, if_id_valid<=1, pc<=pc+4.
REQ-017 Fetch latency is one cycle: the word at pc in cycle N appears on if_id_* in cycle N+1.
REQ-018 Stall without redirect: pc, if_id_pc, if_id_instr and if_id_valid hold their values.
REQ-019 Redirect (stall ignored): pc<={redirect_pc[31:2],2'b00}, if_id_valid<=0, if_id_instr<=0; the in-flight word is discarded.
REQ-020 Redirect with redirect_pc[1:0]!=0: low bits are forced to zero and misaligned=1 in the following cycle only.
REQ-021 The state machine has two states. FETCH: normal operation. HALT: pc >= NUM_INST*4.
REQ-022 FETCH->HALT when the pc register takes a value >= NUM_INST*4. HALT->FETCH only on a redirect to an in-window target.
REQ-023 In HALT: pc holds, halted=1, and a bubble is loaded each unstalled cycle (if_id_valid<=0, if_id_instr<=0).
REQ-024 A redirect to an out-of-window target enters or stays in HALT; no instruction is captured.
REQ-025 PC arithmetic is 32-bit modulo 2^32. Wrap-around is unreachable because HALT is entered first.

Reset
REQ-026 Reset values: pc=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0, misaligned=0. State is FETCH, or HALT if RESET_PC is out of window.
REQ-027 Reset mid-operation overrides any concurrent stall or redirect and discards the IF/ID contents.
REQ-028 The first instruction is captured on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro INST_FETCH_PERF_EN, when defined, adds output fetch_count (32) and output bubble_count (32).
REQ-030 fetch_count increments on each cycle that if_id_valid is loaded with 1.
REQ-031 bubble_count increments on each cycle that if_id_valid is loaded with 0 while stall=0.
REQ-032 Both counters reset to 0, saturate at 32'hFFFF_FFFF, and hold during stall.
REQ-033 Without the macro, neither the counter ports nor the counter logic exist; all other behaviour is identical.

Verification
REQ-034 Sequential fetch: reset, memory[0..2]=A,B,C, no stall -> if_id_instr A,B,C in cycles 1..3; if_id_pc 0,4,8.
REQ-035 Stall: stall=1 for 2 cycles while if_id_pc=4 -> if_id_pc and if_id_instr hold at 4/B, pc holds at 8; C appears one cycle after release.
REQ-036 Redirect: redirect=1, redirect_pc=0x28 while stall=1 -> next cycle if_id_valid=0 and pc=0x28; following cycle if_id_pc=0x28.
REQ-037 Misaligned: redirect_pc=0x2A -> pc=0x28, misaligned=1 for exactly one cycle.
REQ-038 End of memory: NUM_INST=4, no redirect -> after if_id_pc=0xC, halted=1, pc=0x10 holds, if_id_valid=0. Redirect to 0x0 -> halted=0 and fetch resumes.
REQ-039 Reset mid-run: reset=1 together with redirect=1 to 0x40 -> pc=RESET_PC, if_id_valid=0, and counters are 0 when INST_FETCH_PERF_EN is defined.
